uart_frame_parser: RTL

//  Sits downstream of serial_reciever and consumes its first-word-fall-through byte FIFO.

---
 rtl/uart_frame_parser_pkg.sv | 23 ++
 rtl/uart_frame_parser_frame_buf.sv | 55 +++++
 rtl/uart_frame_parser.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_parser_pkg.sv
// Shared types and constants for the UART command-frame parser.
// The parser top and its payload buffer both import this package.
package uart_frame_parser_pkg;

  typedef logic [7:0]  u8;
  typedef logic [15:0] u16;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_CMD,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHK,
    ST_EMIT
  } frame_state_t;

  localparam u8 FRAME_SYNC_DEFAULT = 8'hA5;

  function automatic u16 sat_inc16(input u16 v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/uart_frame_parser_frame_buf.sv
// Payload buffer: simple dual-port RAM with a registered, enabled read port.
// Owns the read pointer so the parser only says "start" or "next" and gets one beat per cycle.
module uart_frame_parser_frame_buf
  import uart_frame_parser_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          srst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          rd_start,
  input  logic          rd_next,
  output logic [7:0]    rd_data
);

  u8             mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  u8             rd_data_q;
  logic          rd_en;

  // rd_ptr_q always names the beat currently sitting in rd_data_q.
  always_comb begin
    rd_en    = rd_start | rd_next;
    rd_ptr_d = rd_ptr_q;
    if (rd_start) begin
      rd_ptr_d = '0;
    end else if (rd_next) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      rd_ptr_q  <= '0;
      rd_data_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      if (rd_en) begin
        rd_data_q <= mem_q[rd_ptr_d];
      end
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/uart_frame_parser.sv
// Parses SYNC|CMD|LEN|PAYLOAD|CHK frames from a FWFT byte FIFO and releases the
// payload on a valid/ready stream only once the checksum has passed.
//   state   | meaning
//   HUNT    | discard bytes until SYNC_BYTE
//   CMD     | next byte is the command
//   LEN     | next byte is the payload length
//   PAYLOAD | store payload bytes into the buffer
//   CHK     | next byte closes the checksum
//   EMIT    | stream buffered payload, input paused
module uart_frame_parser
  import uart_frame_parser_pkg::*;
#(
  parameter u8  SYNC_BYTE      = FRAME_SYNC_DEFAULT,
  parameter int MAX_LEN        = 64,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        srst,
  input  logic [7:0]  in_dout,
  input  logic        in_empty,
  output logic        in_rd_en,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        frame_ok,
  output logic [7:0]  frame_cmd,
  output logic [7:0]  frame_len,
  output logic        err_chk,
  output logic        err_len,
  output logic        err_timeout,
  output logic [15:0] err_count
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES);
  localparam u8 MAX_LEN_U8 = u8'(MAX_LEN);

  frame_state_t     state_q, state_d;
  u8                cmd_q, cmd_d;
  u8                len_q, len_d;
  u8                sum_q, sum_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             frame_ok_q, frame_ok_d;
  u8                frame_cmd_q, frame_cmd_d;
  u8                frame_len_q, frame_len_d;
  logic             err_chk_q, err_chk_d;
  logic             err_len_q, err_len_d;
  logic             err_timeout_q, err_timeout_d;
  u16               err_count_q, err_count_d;

  logic consume;
  logic in_frame;
  logic at_last;
  u8    chk_sum;
  logic buf_wr_en;
  logic buf_rd_start;
  logic buf_rd_next;
  u8    buf_rd_data;

  uart_frame_parser_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (IDX_W)
  ) u_frame_buf (
    .clk      (clk),
    .srst     (srst),
    .wr_en    (buf_wr_en),
    .wr_addr  (idx_q),
    .wr_data  (in_dout),
    .rd_start (buf_rd_start),
    .rd_next  (buf_rd_next),
    .rd_data  (buf_rd_data)
  );

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    len_d         = len_q;
    sum_d         = sum_q;
    idx_d         = idx_q;
    tmo_d         = tmo_q;
    frame_cmd_d   = frame_cmd_q;
    frame_len_d   = frame_len_q;
    frame_ok_d    = 1'b0;
    err_chk_d     = 1'b0;
    err_len_d     = 1'b0;
    err_timeout_d = 1'b0;
    buf_wr_en     = 1'b0;
    buf_rd_start  = 1'b0;
    buf_rd_next   = 1'b0;

    consume  = !in_empty && (state_q != ST_EMIT);
    in_frame = state_q inside {ST_CMD, ST_LEN, ST_PAYLOAD, ST_CHK};
    at_last  = (u8'(idx_q) == len_q - 8'd1);
    chk_sum  = sum_q + in_dout;

    // Inter-byte watchdog; a byte arriving on the terminal cycle still wins.
    if (in_frame) begin
      if (consume) begin
        tmo_d = TMO_LOAD;
      end else if (tmo_q == TMO_W'(1)) begin
        err_timeout_d = 1'b1;
        state_d       = ST_HUNT;
      end else begin
        tmo_d = tmo_q - TMO_W'(1);
      end
    end

    case (state_q)
      ST_HUNT: begin
        if (consume && (in_dout == SYNC_BYTE)) begin
          state_d = ST_CMD;
          tmo_d   = TMO_LOAD;
        end
      end
      ST_CMD: begin
        if (consume) begin
          cmd_d   = in_dout;
          sum_d   = in_dout;
          state_d = ST_LEN;
        end
      end
      ST_LEN: begin
        if (consume) begin
          len_d = in_dout;
          sum_d = chk_sum;
          idx_d = '0;
          if (in_dout > MAX_LEN_U8) begin
            err_len_d = 1'b1;
            state_d   = ST_HUNT;
          end else if (in_dout == 8'd0) begin
            state_d = ST_CHK;
          end else begin
            state_d = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (consume) begin
          buf_wr_en = 1'b1;
          sum_d     = chk_sum;
          if (at_last) begin
            state_d = ST_CHK;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_CHK: begin
        if (consume) begin
          if (chk_sum == 8'h00) begin
            frame_ok_d  = 1'b1;
            frame_cmd_d = cmd_q;
            frame_len_d = len_q;
            if (len_q != 8'd0) begin
              // Prefetch beat 0 now so it is on out_data when EMIT begins.
              state_d      = ST_EMIT;
              idx_d        = '0;
              buf_rd_start = 1'b1;
            end else begin
              state_d = ST_HUNT;
            end
          end else begin
            err_chk_d = 1'b1;
            state_d   = ST_HUNT;
          end
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          if (at_last) begin
            state_d = ST_HUNT;
          end else begin
            idx_d       = idx_q + IDX_W'(1);
            buf_rd_next = 1'b1;
          end
        end
      end
      default: state_d = ST_HUNT;
    endcase

    err_count_d = (err_chk_d || err_len_d || err_timeout_d) ? sat_inc16(err_count_q) : err_count_q;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q       <= ST_HUNT;
      cmd_q         <= '0;
      len_q         <= '0;
      sum_q         <= '0;
      idx_q         <= '0;
      tmo_q         <= '0;
      frame_ok_q    <= 1'b0;
      frame_cmd_q   <= '0;
      frame_len_q   <= '0;
      err_chk_q     <= 1'b0;
      err_len_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      err_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      len_q         <= len_d;
      sum_q         <= sum_d;
      idx_q         <= idx_d;
      tmo_q         <= tmo_d;
      frame_ok_q    <= frame_ok_d;
      frame_cmd_q   <= frame_cmd_d;
      frame_len_q   <= frame_len_d;
      err_chk_q     <= err_chk_d;
      err_len_q     <= err_len_d;
      err_timeout_q <= err_timeout_d;
      err_count_q   <= err_count_d;
    end
  end

  assign in_rd_en    = consume;
  assign out_valid   = (state_q == ST_EMIT);
  assign out_last    = out_valid && at_last;
  assign out_data    = buf_rd_data;
  assign frame_ok    = frame_ok_q;
  assign frame_cmd   = frame_cmd_q;
  assign frame_len   = frame_len_q;
  assign err_chk     = err_chk_q;
  assign err_len     = err_len_q;
  assign err_timeout = err_timeout_q;
  assign err_count   = err_count_q;

endmodule
